id_ex_stage_reg: RTL

//  ID/EX pipeline register of the 5-stage MIPS core. Captures decoded controls, immediates and the two

---
 rtl/id_ex_stage_reg_if.sv | 29 ++
 rtl/id_ex_stage_reg.sv | 74 +++++++
 2 files changed

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_if: ID-side operands, WB bypass inputs and EX-side registered outputs of the ID/EX register
interface id_ex_if #(parameter int CTRL_W = 12, parameter int CNT_W = 16);
    logic              id_valid;
    logic [31:0]       id_pc, id_imm, id_rs_data, id_rt_data;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_RegWrite;
    logic [4:0]        wb_write_addr;
    logic [31:0]       wb_write_data;
    logic              flush, ex_hold;
    logic              ex_valid;
    logic [31:0]       ex_pc, ex_imm, ex_rs_data, ex_rt_data;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall_id;
    logic [CNT_W-1:0]  bubble_cnt;
    modport master (
        output id_valid, id_pc, id_imm, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_ctrl,
               wb_RegWrite, wb_write_addr, wb_write_data, flush, ex_hold,
        input  ex_valid, ex_pc, ex_imm, ex_rs_data, ex_rt_data, ex_rs, ex_rt, ex_rd, ex_ctrl,
               stall_id, bubble_cnt
    );
    modport slave (
        input  id_valid, id_pc, id_imm, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_ctrl,
               wb_RegWrite, wb_write_addr, wb_write_data, flush, ex_hold,
        output ex_valid, ex_pc, ex_imm, ex_rs_data, ex_rt_data, ex_rs, ex_rt, ex_rd, ex_ctrl,
               stall_id, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubbling, WB bypass and hold-time operand refresh
module id_ex_stage_reg #(
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input logic   clk,
    input logic   reset,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [31:0]       pc, imm;
        logic [4:0]        rs, rt, rd;
        logic [31:0]       rs_data, rt_data;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t              ex, ld;
    logic [CNT_W-1:0] cnt;
    logic             load_use;

    function automatic logic [31:0] bypass(input logic [4:0] a, input logic [31:0] d,
                                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
        return (we && wa != 5'd0 && wa == a) ? wd : d;
    endfunction

    assign load_use = ex.valid & ex.ctrl[1] & bus.id_valid & (ex.rt != 5'd0) &
                      ((ex.rt == bus.id_rs) | (ex.rt == bus.id_rt));
    assign bus.stall_id = ~bus.flush & (bus.ex_hold | load_use);

    // next EX contents when the ID instruction is accepted
    always_comb begin
        ld = '{valid:   bus.id_valid,
               pc:      bus.id_pc,
               imm:     bus.id_imm,
               rs:      bus.id_rs,
               rt:      bus.id_rt,
               rd:      bus.id_rd,
               rs_data: bypass(bus.id_rs, bus.id_rs_data, bus.wb_RegWrite, bus.wb_write_addr, bus.wb_write_data),
               rt_data: bypass(bus.id_rt, bus.id_rt_data, bus.wb_RegWrite, bus.wb_write_addr, bus.wb_write_data),
               ctrl:    bus.id_valid ? bus.id_ctrl : '0};
    end

    // flush beats hold, hold beats load-use bubble, otherwise load from ID
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex  <= '0;
            cnt <= '0;
        end else if (bus.flush) begin
            ex <= '0;
        end else if (bus.ex_hold) begin
            if (ex.valid) begin
                ex.rs_data <= bypass(ex.rs, ex.rs_data, bus.wb_RegWrite, bus.wb_write_addr, bus.wb_write_data);
                ex.rt_data <= bypass(ex.rt, ex.rt_data, bus.wb_RegWrite, bus.wb_write_addr, bus.wb_write_data);
            end
        end else if (load_use) begin
            ex <= '0;
            if (~&cnt) cnt <= cnt + 1'b1;
        end else begin
            ex <= ld;
        end
    end

    assign bus.ex_valid   = ex.valid;
    assign bus.ex_pc      = ex.pc;
    assign bus.ex_imm     = ex.imm;
    assign bus.ex_rs      = ex.rs;
    assign bus.ex_rt      = ex.rt;
    assign bus.ex_rd      = ex.rd;
    assign bus.ex_rs_data = ex.rs_data;
    assign bus.ex_rt_data = ex.rt_data;
    assign bus.ex_ctrl    = ex.ctrl;
    assign bus.bubble_cnt = cnt;
endmodule
